regfile: RTL
============

Name: regfile

Overview:
- 32 x 32-bit general-purpose register file: the consumer end of the writeback interface driven by the MEM/WB pipeline register.
- Sits between the WB stage (write port) and the ID stage (two read ports).
- Writes commit on the clock edge. Reads are combinational, with same-cycle write-to-read bypass, so ID sees a value being retired in WB without an extra stall.
- x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits; matches the RegBus width.
- ADDR_W, 5, register index width; matches the RegAddrBus width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- rdy  input  1  global ready; when low, state is frozen.
- we  input  1  write enable from WB (wb_wreg).
- waddr  input  ADDR_W  destination register index from WB (wb_wd).
- wdata  input  DATA_W  write data from WB (wb_wdata).
- re1  input  1  read-port-1 enable from ID.
- raddr1  input  ADDR_W  read-port-1 register index.
- rdata1  output  DATA_W  read-port-1 data (combinational).
- re2  input  1  read-port-2 enable from ID.
- raddr2  input  ADDR_W  read-port-2 register index.
- rdata2  output  DATA_W  read-port-2 data (combinational).

Behaviour:
- Reset:
  - rst=1 at a rising clk edge clears all NUM_REGS entries to 0.
  - While rst=1, rdata1 and rdata2 are 0 regardless of the other inputs.
  - Reset wins over a simultaneous write.
  - Reset asserted mid-program discards all register contents; the first write after reset is accepted on the first edge with rst=0.
- Write:
  - On a rising edge with rst=0, rdy=1, we=1 and waddr!=0: regs[waddr] <= wdata. Latency is 1 edge.
  - we=0: no state change.
  - rdy=0: no state change, even with we=1 (the write is lost; upstream holds it per the stall protocol).
  - waddr=0: write silently discarded; regs[0] stays 0.
  - The WB bubble (we=0, waddr=0, wdata=0) has no effect.
- Read priority, evaluated independently per port n, first match wins:
  1. rst=1 -> 0.
  2. ren=0 -> 0.
  3. raddrn=0 -> 0.
  4. Bypass: we=1, rdy=1 and waddr==raddrn -> wdata.
  5. Otherwise -> regs[raddrn].
- Read ports:
  - Both ports may address the same register in the same cycle; both receive identical data, including the bypass value.
  - There are no read side effects.
  - Reads are served while rdy=0; bypass is disabled then because the write will not commit.
- Arithmetic: none. Data is stored and returned bit-exact, no sign or width conversion.
- Storage: plain register array, no reset-dependent initial values beyond the clear.

Test Plan:
- Reset clear: preload x5=0xDEADBEEF, assert rst for 1 edge, re1=1, raddr1=5 -> rdata1=0 during and after reset; with rst=1 and we=1, waddr=3, wdata=0x11 on the same edge -> x3 reads 0 afterwards.
- Basic write/read: we=1, waddr=7, wdata=0x12345678 for 1 edge, then we=0, re1=1, raddr1=7 and re2=1, raddr2=7 -> rdata1 and rdata2 both 0x12345678.
- Bypass: x9 holds 0x1; same cycle we=1, waddr=9, wdata=0xCAFEF00D, re2=1, raddr2=9 -> rdata2=0xCAFEF00D before the edge; after the edge, with we=0 -> 0xCAFEF00D.
- x0 hardwire: we=1, waddr=0, wdata=0xFFFFFFFF, re1=1, raddr1=0 -> rdata1=0 in the same cycle and after the edge.
- rdy freeze: rdy=0, we=1, waddr=4, wdata=0xAA -> rdata1 (raddr1=4) shows the old value 0 with no bypass; after the edge x4 is still 0. Then rdy=1 for 1 edge -> x4=0xAA.
- Read enable gating: x6=0x55, re1=0, raddr1=6 -> rdata1=0; re1=1 -> rdata1=0x55.

Source files
------------

// File: rtl/regfile.sv
// 32 x 32-bit register file: one write port fed by WB, two combinational read
// ports for ID with same-cycle write-to-read bypass. x0 always reads zero.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // A write commits only when it will really retire this edge: rdy high
  // (no stall) and a non-zero destination. The same condition gates bypass.
  logic wr_commit;
  assign wr_commit = we && rdy && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (wr_commit && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (wr_commit && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs[raddr2];
      end
    end
  end

endmodule
